// File: rtl/apb_timer_pkg.sv
// Shared definitions for the APB timer: register byte offsets, CTRL bit positions, counter FSM states.
// Latency: n/a (definitions only).
// Backpressure: n/a (definitions only).
package apb_timer_pkg;

  // Byte offsets inside the slave window. Only paddr[4:2] selects a register.
  localparam logic [4:0] OFS_CTRL   = 5'h00;
  localparam logic [4:0] OFS_LOAD   = 5'h04;
  localparam logic [4:0] OFS_VALUE  = 5'h08;
  localparam logic [4:0] OFS_STATUS = 5'h0C;
  localparam logic [4:0] OFS_PRESC  = 5'h10;

  // CTRL bit indices
  localparam int CTRL_EN = 0;
  localparam int CTRL_AR = 1;
  localparam int CTRL_IE = 2;
  localparam int CTRL_W  = 3;

  typedef enum logic {
    T_IDLE = 1'b0,
    T_RUN  = 1'b1
  } tmr_state_e;

  // Word-aligned register offset from the low address bits.
  function automatic logic [4:0] word_ofs(input logic [4:0] a);
    return {a[4:2], 2'b00};
  endfunction

endpackage

// File: rtl/apb_timer_core.sv
// Counter engine: 2-state FSM, 32-bit down-counter with reload, expiry pulse, optional prescaler.
// Latency: VALUE updates on the tick edge; exp_o is combinational from state and VALUE.
// Backpressure: none; load strobes are always accepted and override the tick in the same cycle.
//
// Ports:
//   clk_i, rst_ni    clock, asynchronous active-low reset
//   en_next_i        next-cycle value of CTRL.EN (APB write or one-shot clear already applied)
//   ar_i             CTRL.AR auto-reload
//   load_wr_i        LOAD write strobe; load_dat_i is copied into VALUE
//   reload_dat_i     current LOAD register, used on auto-reload
//   presc_i, presc_wr_i  prescale compare value and its write strobe (TIMER_PRESC_EN only)
//   value_o          VALUE register
//   exp_o            one-cycle expiry pulse (tick taken with VALUE==0)
//
// Build option: define TIMER_PRESC_EN to add the 8-bit prescaler; otherwise every cycle ticks.
module apb_timer_core
  import apb_timer_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        en_next_i,
  input  logic        ar_i,
  input  logic        load_wr_i,
  input  logic [31:0] load_dat_i,
  input  logic [31:0] reload_dat_i,
`ifdef TIMER_PRESC_EN
  input  logic [7:0]  presc_i,
  input  logic        presc_wr_i,
`endif
  output logic [31:0] value_o,
  output logic        exp_o
);

  tmr_state_e  state_q, state_d;
  logic [31:0] value_q, value_d;
  logic        run;
  logic        tick;

  // ---------------- state register ----------------
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= T_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // ---------------- next-state logic ----------------
  // en_next_i already folds in the one-shot expiry clear of EN, so leaving RUN on
  // expiry and on a software EN=0 are the same transition. An APB write of EN=1 in
  // the expiry cycle keeps the timer in RUN.
  always_comb begin
    state_d = state_q;
    case (state_q)
      T_IDLE:  if (en_next_i)  state_d = T_RUN;
      T_RUN:   if (!en_next_i) state_d = T_IDLE;
      default: state_d = T_IDLE;
    endcase
  end

  // ---------------- prescaler ----------------
`ifdef TIMER_PRESC_EN
  logic [7:0] pcnt_q, pcnt_d;
  logic       start;

  // EN 0->1 is the edge that moves the FSM out of IDLE.
  assign start = (state_q == T_IDLE) && en_next_i;
  assign tick  = (pcnt_q == presc_i);

  always_comb begin
    pcnt_d = pcnt_q;
    if (start || presc_wr_i) begin
      pcnt_d = 8'd0;
    end else if (state_q == T_RUN) begin
      pcnt_d = tick ? 8'd0 : pcnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      pcnt_q <= 8'd0;
    end else begin
      pcnt_q <= pcnt_d;
    end
  end
`else
  assign tick = 1'b1;
`endif

  // ---------------- outputs / datapath ----------------
  // A LOAD write consumes the tick of its cycle entirely: no decrement, no expiry.
  always_comb begin
    run     = (state_q == T_RUN);
    exp_o   = run && tick && (value_q == 32'd0) && !load_wr_i;
    value_d = value_q;
    if (load_wr_i) begin
      value_d = load_dat_i;
    end else if (run && tick) begin
      if (value_q != 32'd0) begin
        value_d = value_q - 32'd1;
      end else if (ar_i) begin
        value_d = reload_dat_i;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      value_q <= 32'd0;
    end else begin
      value_q <= value_d;
    end
  end

  assign value_o = value_q;

endmodule

// File: rtl/apb_timer_slave.sv
// Zero-wait-state APB timer slave: register file, address decode, prdata capture, irq.
// Latency: writes commit on the enable edge; read data is registered on the setup edge.
// Backpressure: none; there is no pready, every access is setup + enable.
//
// Ports:
//   hclk, hrstn          clock, asynchronous active-low reset
//   psel, penable        APB phase controls
//   pwrite, paddr, pwdata  APB command, address, write data
//   prdata               registered read data, held until the next read setup
//   irq                  level interrupt, STATUS.EXP & CTRL.IE
//
// Build option: define TIMER_PRESC_EN to map PRESC at 0x10 and enable the prescaler.
module apb_timer_slave
  import apb_timer_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned DEC_W     = 12
) (
  input  logic        hclk,
  input  logic        hrstn,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [31:0] paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        irq
);

  logic              hit;
  logic              setup_ph;
  logic              setup_rd;
  logic              wr_en;
  logic              wr_hit_q;
  logic [4:0]        wr_ofs_q;
  logic              ctrl_wr, load_wr, status_wr;
  logic [CTRL_W-1:0] ctrl_q, ctrl_d;
  logic [31:0]       load_q, load_d;
  logic              exp_q, exp_d;
  logic [31:0]       prdata_q, prdata_d;
  logic [31:0]       rd_dat;
  logic [31:0]       value;
  logic              exp_pulse;
  logic              unused_paddr_lo;

  assign unused_paddr_lo = ^paddr[1:0];

  // Slave owns the DEC_W window; only the first 32 bytes hold registers.
  assign hit = (paddr[31:DEC_W] == BASE_ADDR[31:DEC_W]) &&
               (paddr[DEC_W-1:5] == '0);

  assign setup_ph = psel & ~penable;
  assign setup_rd = setup_ph & ~pwrite;

  // The bridge zeroes paddr in the enable phase, so the decode taken at setup is
  // what steers the write that commits on the enable edge.
  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      wr_hit_q <= 1'b0;
      wr_ofs_q <= 5'd0;
    end else if (setup_ph) begin
      wr_hit_q <= hit;
      wr_ofs_q <= word_ofs(paddr[4:0]);
    end
  end

  assign wr_en     = psel & penable & pwrite & wr_hit_q;
  assign ctrl_wr   = wr_en && (wr_ofs_q == OFS_CTRL);
  assign load_wr   = wr_en && (wr_ofs_q == OFS_LOAD);
  assign status_wr = wr_en && (wr_ofs_q == OFS_STATUS);

  // ---------------- PRESC register ----------------
`ifdef TIMER_PRESC_EN
  logic       presc_wr;
  logic [7:0] presc_q, presc_d;

  assign presc_wr = wr_en && (wr_ofs_q == OFS_PRESC);

  always_comb begin
    presc_d = presc_q;
    if (presc_wr) presc_d = pwdata[7:0];
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      presc_q <= 8'd0;
    end else begin
      presc_q <= presc_d;
    end
  end
`endif

  // ---------------- CTRL / LOAD / STATUS ----------------
  always_comb begin
    ctrl_d = ctrl_q;
    if (ctrl_wr) begin
      ctrl_d = pwdata[CTRL_W-1:0];
    end else if (exp_pulse && !ctrl_q[CTRL_AR]) begin
      // one-shot expiry stops the timer unless software rewrites CTRL this cycle
      ctrl_d[CTRL_EN] = 1'b0;
    end
  end

  always_comb begin
    load_d = load_q;
    if (load_wr) load_d = pwdata;
  end

  // A fresh expiry beats a simultaneous write-1-to-clear.
  always_comb begin
    exp_d = exp_q;
    if (exp_pulse) begin
      exp_d = 1'b1;
    end else if (status_wr && pwdata[0]) begin
      exp_d = 1'b0;
    end
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      ctrl_q <= '0;
      load_q <= 32'd0;
      exp_q  <= 1'b0;
    end else begin
      ctrl_q <= ctrl_d;
      load_q <= load_d;
      exp_q  <= exp_d;
    end
  end

  // ---------------- counter engine ----------------
  apb_timer_core u_core (
    .clk_i        (hclk),
    .rst_ni       (hrstn),
    .en_next_i    (ctrl_d[CTRL_EN]),
    .ar_i         (ctrl_q[CTRL_AR]),
    .load_wr_i    (load_wr),
    .load_dat_i   (pwdata),
    .reload_dat_i (load_q),
`ifdef TIMER_PRESC_EN
    .presc_i      (presc_q),
    .presc_wr_i   (presc_wr),
`endif
    .value_o      (value),
    .exp_o        (exp_pulse)
  );

  // ---------------- read path ----------------
  always_comb begin
    rd_dat = 32'd0;
    if (hit) begin
      case (word_ofs(paddr[4:0]))
        OFS_CTRL:   rd_dat = 32'(ctrl_q);
        OFS_LOAD:   rd_dat = load_q;
        OFS_VALUE:  rd_dat = value;
        OFS_STATUS: rd_dat = 32'(exp_q);
`ifdef TIMER_PRESC_EN
        OFS_PRESC:  rd_dat = 32'(presc_q);
`endif
        default:    rd_dat = 32'd0;
      endcase
    end
  end

  // Captured at the setup edge while paddr is still valid; held otherwise.
  always_comb begin
    prdata_d = prdata_q;
    if (setup_rd) prdata_d = rd_dat;
  end

  always_ff @(posedge hclk or negedge hrstn) begin
    if (!hrstn) begin
      prdata_q <= 32'd0;
    end else begin
      prdata_q <= prdata_d;
    end
  end

  assign prdata = prdata_q;
  assign irq    = exp_q & ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_apb_timer_slave.sv
// Directed bench for apb_timer_slave: register access, one-shot and auto-reload counting, irq, decode holes, reset.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_apb_timer_slave;

  logic        hclk = 1'b0;
  logic        hrstn;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        irq;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] rd;

  always #5 hclk = ~hclk;

  apb_timer_slave #(
    .BASE_ADDR (32'h0000_0000),
    .DEC_W     (12)
  ) dut (
    .hclk    (hclk),
    .hrstn   (hrstn),
    .psel    (psel),
    .penable (penable),
    .pwrite  (pwrite),
    .paddr   (paddr),
    .pwdata  (pwdata),
    .prdata  (prdata),
    .irq     (irq)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, then step 1 time unit past the edge.
  task automatic cyc(input int n);
    repeat (n) @(posedge hclk);
    #1;
  endtask

  // Called just after an edge; setup at next edge, commit at the one after.
  task automatic apb_write(input logic [31:0] addr, input logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = addr; pwdata = data;
    cyc(1);
    penable = 1'b1;
    cyc(1);
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0; paddr = 32'd0; pwdata = 32'd0;
  endtask

  // Bridge-style read: paddr driven to 0 during the enable phase.
  task automatic apb_read(input logic [31:0] addr, output logic [31:0] data);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = addr;
    cyc(1);
    penable = 1'b1; paddr = 32'd0;
    cyc(1);
    data = prdata;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

  initial begin
    hrstn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 32'd0; pwdata = 32'd0;
    #12;
    check("reset_prdata", prdata, 32'd0);
    check("reset_irq", 32'(irq), 32'd0);
    hrstn = 1'b1;
    cyc(1);

    // Reset values
    apb_read(32'h00, rd); check("reset_ctrl", rd, 32'd0);
    apb_read(32'h04, rd); check("reset_load", rd, 32'd0);
    apb_read(32'h08, rd); check("reset_value", rd, 32'd0);
    apb_read(32'h0C, rd); check("reset_status", rd, 32'd0);

    // One-shot: LOAD=5, EN. Enable edge A: value 5; A+1..A+5 -> 4..0; EXP at A+6.
    apb_write(32'h04, 32'd5);
    apb_write(32'h00, 32'h1);
    apb_read(32'h08, rd); check("oneshot_val_a1", rd, 32'd5);
    apb_read(32'h08, rd); check("oneshot_val_a3", rd, 32'd3);
    apb_read(32'h0C, rd); check("oneshot_exp_early", rd, 32'd0);
    apb_read(32'h0C, rd); check("oneshot_exp_set", rd, 32'd1);
    apb_read(32'h08, rd); check("oneshot_val_zero", rd, 32'd0);
    apb_read(32'h00, rd); check("oneshot_en_clr", rd, 32'd0);
    check("oneshot_irq_masked", 32'(irq), 32'd0);
    apb_write(32'h0C, 32'h1);
    apb_read(32'h0C, rd); check("w1c_status", rd, 32'd0);

    // Auto-reload with irq: LOAD=3, CTRL=7 at edge B+2 -> expiries at B+6, B+10, B+14.
    apb_write(32'h04, 32'd3);
    apb_write(32'h00, 32'h7);
    cyc(3); check("ar_irq_before", 32'(irq), 32'd0);
    cyc(1); check("ar_irq_first", 32'(irq), 32'd1);
    apb_write(32'h0C, 32'h1);
    check("ar_irq_cleared", 32'(irq), 32'd0);
    cyc(1); check("ar_irq_still_low", 32'(irq), 32'd0);
    cyc(1); check("ar_irq_second", 32'(irq), 32'd1);
    cyc(2);
    apb_write(32'h0C, 32'h1);
    check("ar_w1c_vs_expiry", 32'(irq), 32'd1);
    apb_read(32'h08, rd); check("ar_reloaded", rd, 32'd3);
    apb_write(32'h00, 32'h0);
    apb_write(32'h0C, 32'h1);
    check("ar_stopped_irq", 32'(irq), 32'd0);

    // VALUE decoded from the setup address, not the zeroed enable address
    apb_write(32'h04, 32'h1234_5678);
    apb_read(32'h08, rd); check("value_decode", rd, 32'h1234_5678);
    apb_read(32'h04, rd); check("load_readback", rd, 32'h1234_5678);
    apb_write(32'h08, 32'h0000_DEAD);
    apb_read(32'h08, rd); check("value_ro", rd, 32'h1234_5678);

    // Decode holes and base mismatch
    apb_write(32'h1C, 32'hFFFF_FFFF);
    apb_read(32'h1C, rd); check("unmapped_read", rd, 32'd0);
    apb_read(32'h00, rd); check("unmapped_no_ctrl", rd, 32'd0);
    apb_write(32'h0000_1004, 32'h0000_AAAA);
    apb_read(32'h0000_1008, rd); check("mismatch_read", rd, 32'd0);
    apb_read(32'h04, rd); check("mismatch_no_load", rd, 32'h1234_5678);

    // LOAD write during a tick: write wins, no decrement
    apb_write(32'h04, 32'd100);
    apb_write(32'h00, 32'h3);
    apb_write(32'h04, 32'd10);
    apb_read(32'h08, rd); check("load_beats_tick", rd, 32'd10);
    apb_write(32'h00, 32'h0);

`ifdef TIMER_PRESC_EN
    // PRESC=2, LOAD=1: ticks every 3 cycles, EXP 6 cycles after the EN edge
    apb_write(32'h10, 32'd2);
    apb_read(32'h10, rd); check("presc_readback", rd, 32'd2);
    apb_write(32'h04, 32'd1);
    apb_write(32'h00, 32'h5);
    cyc(4); check("presc_irq_before", 32'(irq), 32'd0);
    cyc(1); check("presc_irq_at6", 32'(irq), 32'd1);
    apb_write(32'h00, 32'h0);
    apb_write(32'h0C, 32'h1);
    apb_write(32'h10, 32'd0);
`else
    apb_write(32'h10, 32'h0000_00FF);
    apb_read(32'h10, rd); check("presc_unmapped", rd, 32'd0);
    apb_read(32'h00, rd); check("presc_no_ctrl", rd, 32'd0);
`endif

    // LOAD=0 with AR: EXP every tick, so W1C can never win
    apb_write(32'h04, 32'd0);
    apb_write(32'h00, 32'h7);
    cyc(1); check("load0_irq", 32'(irq), 32'd1);
    apb_write(32'h0C, 32'h1);
    check("load0_w1c_loses", 32'(irq), 32'd1);
    apb_read(32'h00, rd); check("load0_ctrl", rd, 32'd7);

    // Reset mid-count, mid-cycle
    #2;
    hrstn = 1'b0;
    #1;
    check("midreset_prdata", prdata, 32'd0);
    check("midreset_irq", 32'(irq), 32'd0);
    #3;
    hrstn = 1'b1;
    cyc(1);
    apb_read(32'h08, rd); check("post_reset_value", rd, 32'd0);
    apb_read(32'h00, rd); check("post_reset_ctrl", rd, 32'd0);
    apb_read(32'h0C, rd); check("post_reset_status", rd, 32'd0);
    check("post_reset_irq", 32'(irq), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
